// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; master drives the request, slave computes.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, retiring BITS_PER_CYCLE bits per clock through a borrow chain
// with the inter-chunk borrow held in a flop.
module serial_subtractor #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int unsigned Bpc  = (BITS_PER_CYCLE == 0) ? 1 : BITS_PER_CYCLE;
  localparam int unsigned N    = WIDTH / Bpc;
  localparam int unsigned CntW = $clog2(N + 1);

  if (WIDTH < 2 || BITS_PER_CYCLE == 0 || (WIDTH % Bpc) != 0) begin : g_param_check
    $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic             br_q, br_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [Bpc-1:0]       chunk;
  logic                 chunk_bout;
  logic                 msb_borrow;
  logic [WIDTH+Bpc-1:0] r_cat;
  logic [WIDTH-1:0]     r_shift;
  logic                 last_pass;

  // Ripple the borrow through the low Bpc bits; the borrow entering the top cell of the
  // chunk is the borrow into bit WIDTH-1 on the final pass.
  always_comb begin
    logic c;
    chunk      = '0;
    msb_borrow = 1'b0;
    c          = br_q;
    for (int i = 0; i < int'(Bpc); i++) begin
      chunk[i] = a_q[i] ^ b_q[i] ^ c;
      if (i == int'(Bpc) - 1) msb_borrow = c;
      c = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & c);
    end
    chunk_bout = c;
  end

  assign r_cat     = {chunk, r_q};
  assign r_shift   = r_cat[WIDTH+Bpc-1:Bpc];
  assign last_pass = (cnt_q == CntW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          state_d = StRun;
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
        end
      end
      StRun: begin
        a_d   = a_q >> Bpc;
        b_d   = b_q >> Bpc;
        r_d   = r_shift;
        br_d  = chunk_bout;
        cnt_d = cnt_q + 1'b1;
        // Results are published on the edge that enters DONE.
        if (last_pass) begin
          state_d = StDone;
          diff_d  = r_shift;
          bout_d  = chunk_bout;
          ovf_d   = msb_borrow ^ chunk_bout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Drives a bit-serial (BPC=1) and a nibble-wide (BPC=4) instance with shared stimulus and
// compares both against an arithmetic reference every cycle.
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         start  = 1'b0;
  logic [W-1:0] a_in   = '0;
  logic [W-1:0] b_in   = '0;
  logic         bin_in = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) if1 ();
  serial_subtractor_if #(.WIDTH(W)) if4 ();

  assign if1.start = start;
  assign if1.a     = a_in;
  assign if1.b     = b_in;
  assign if1.bin   = bin_in;
  assign if4.start = start;
  assign if4.a     = a_in;
  assign if4.b     = b_in;
  assign if4.bin   = bin_in;

  serial_subtractor #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  serial_subtractor #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void ref_sub(input bit [7:0] x, input bit [7:0] y, input bit bi,
                                  output bit [7:0] d, output bit bo, output bit ov);
    int u;
    int s;
    u  = int'(x) - int'(y) - int'(bi);
    s  = int'($signed(x)) - int'($signed(y)) - int'(bi);
    d  = u[7:0];
    bo = (u < 0);
    ov = (s < -128) || (s > 127);
  endfunction

  function automatic int npass(input int k);
    return (k == 0) ? 8 : 2;
  endfunction

  // Reference: an accepted op keeps the block busy for N edges, then shows done for one.
  int       m_left [2];
  bit       m_done [2];
  bit [7:0] m_diff [2];
  bit       m_bout [2];
  bit       m_ovf  [2];
  bit [7:0] p_diff [2];
  bit       p_bout [2];
  bit       p_ovf  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_left[k] = 0;
        m_done[k] = 1'b0;
        m_diff[k] = '0;
        m_bout[k] = 1'b0;
        m_ovf[k]  = 1'b0;
      end else if (m_left[k] > 0) begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          m_done[k] = 1'b1;
          m_diff[k] = p_diff[k];
          m_bout[k] = p_bout[k];
          m_ovf[k]  = p_ovf[k];
        end
      end else begin
        m_done[k] = 1'b0;
        if (start) begin
          m_left[k] = npass(k);
          ref_sub(a_in, b_in, bin_in, p_diff[k], p_bout[k], p_ovf[k]);
        end
      end
    end
  end

  logic       dut_busy [2];
  logic       dut_done [2];
  logic [7:0] dut_diff [2];
  logic       dut_bout [2];
  logic       dut_ovf  [2];

  assign dut_busy[0] = if1.busy;
  assign dut_busy[1] = if4.busy;
  assign dut_done[0] = if1.done;
  assign dut_done[1] = if4.done;
  assign dut_diff[0] = if1.diff;
  assign dut_diff[1] = if4.diff;
  assign dut_bout[0] = if1.bout;
  assign dut_bout[1] = if4.bout;
  assign dut_ovf[0]  = if1.ovf;
  assign dut_ovf[1]  = if4.ovf;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      string tag;
      tag = (k == 0) ? "bpc1" : "bpc4";
      check({tag, ".busy"}, 32'(dut_busy[k]), 32'(m_left[k] > 0));
      check({tag, ".done"}, 32'(dut_done[k]), 32'(m_done[k]));
      check({tag, ".diff"}, 32'(dut_diff[k]), 32'(m_diff[k]));
      check({tag, ".bout"}, 32'(dut_bout[k]), 32'(m_bout[k]));
      check({tag, ".ovf"},  32'(dut_ovf[k]),  32'(m_ovf[k]));
    end
  end

  // One op with literal expectations; optional ignored start pulse at pass `mid`.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] ed, input logic ebo,
                        input logic eov, input int mid);
    int lat1;
    int lat4;
    logic [7:0] d4;
    lat1 = -1;
    lat4 = -1;
    d4   = '0;
    @(negedge clk);
    a_in = a; b_in = b; bin_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (if4.done && lat4 < 0) begin
        lat4 = i;
        d4   = if4.diff;
      end
      if (if1.done) begin
        lat1 = i;
        break;
      end
      if (i == mid) begin
        start = 1'b1; a_in = ~a; b_in = a; bin_in = ~bi;
      end else if (i == mid + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({name, ".lat_bpc1"},  32'(lat1), 32'd8);
    check({name, ".diff_bpc1"}, 32'(if1.diff), 32'(ed));
    check({name, ".bout_bpc1"}, 32'(if1.bout), 32'(ebo));
    check({name, ".ovf_bpc1"},  32'(if1.ovf),  32'(eov));
    check({name, ".lat_bpc4"},  32'(lat4), 32'd2);
    check({name, ".diff_bpc4"}, 32'(d4), 32'(ed));
  endtask

  initial begin
    int t1 [$];
    int t4 [$];

    #12;
    check("reset.busy", 32'(if1.busy), 32'd0);
    check("reset.diff", 32'(if1.diff), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    run_op("basic",    8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);
    run_op("under",    8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0);
    run_op("bin",      8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op("ovf_neg",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    run_op("parallel", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 0);
    run_op("midstart", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 3);

    // Back-to-back: start held high, operands changing every cycle.
    repeat (10) @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a_in   = 8'($urandom);
      b_in   = 8'($urandom);
      bin_in = 1'($urandom);
      @(negedge clk);
      if (if1.done) t1.push_back(i);
      if (if4.done) t4.push_back(i);
    end
    start = 1'b0;
    check("b2b.count_bpc1", 32'(t1.size() >= 2), 32'd1);
    check("b2b.count_bpc4", 32'(t4.size() >= 2), 32'd1);
    if (t1.size() >= 2) check("b2b.period_bpc1", 32'(t1[1] - t1[0]), 32'd9);
    if (t4.size() >= 2) check("b2b.period_bpc4", 32'(t4[1] - t4[0]), 32'd3);

    // Reset mid-RUN, with known nonzero outputs beforehand.
    repeat (10) @(negedge clk);
    run_op("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);
    @(negedge clk);
    a_in = 8'h10; b_in = 8'h01; bin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.busy", 32'(if1.busy), 32'd0);
    check("rst_mid.done", 32'(if1.done), 32'd0);
    check("rst_mid.diff", 32'(if1.diff), 32'd0);
    check("rst_mid.bout", 32'(if1.bout), 32'd0);
    check("rst_mid.ovf",  32'(if1.ovf),  32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op("after_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0);

    // Random traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 3) == 0);
      a_in   = 8'($urandom);
      b_in   = 8'($urandom);
      bin_in = 1'($urandom);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
